fifo_word_packer: RTL and testbench

- Read-side consumer of the team's sync_fifo. Drains 8-bit entries with fifo_rd_en and packs them little-endian into 32-bit words on a valid/ready output stream.
- A flush input emits a partial word with byte-enables.
- Sits between the byte FIFO and word-wide downstream logic (bus master / DMA beat builder).

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/word_out_reg.sv | 50 +++++
 rtl/fifo_word_packer.sv | 164 ++++++++++++++++
 tb/tb_fifo_word_packer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared definitions for the byte-FIFO to word packer:
//     - pack_state_e : packer FSM encoding
//     - pack_lanes() : entries per output word (N)
//     - cnt_width()  : width of a counter that must hold 0..N inclusive
//     - DEF_*        : default entry / word widths
package fifo_pkg;

   typedef enum logic [1:0] {
      FILL       = 2'd0,  // popping entries into the assembly register
      HOLD       = 2'd1,  // full word assembled, output register busy
      FLUSH_WAIT = 2'd2,  // flush seen, letting an in-flight read land
      HOLD_F     = 2'd3   // partial word waiting for the output register
   } pack_state_e;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_WORD_WIDTH = 32;

   function automatic int pack_lanes(input int data_width, input int word_width);
      return word_width / data_width;
   endfunction

   // The lane counter sits at N while a full word waits, so it needs N+1 codes.
   function automatic int cnt_width(input int lanes);
      return $clog2(lanes + 1);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO. RDATA_MODE 0 presents the head entry combinationally
//   (rd_data valid in the rd_en cycle); RDATA_MODE 1 registers it (rd_data
//   valid the cycle after rd_en). overflow/underflow pulse one cycle after a
//   write while full / read while empty.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wr_en, wr_data      push side, full
//   rd_en, rd_data      pop side, empty
//   overflow, underflow error pulses
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int RDATA_MODE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW:0]           wptr, rptr;
   logic                  do_wr, do_rd;

   // extra pointer MSB tells full from empty when the indices match
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (do_wr) wptr <= wptr + (AW+1)'(1);
         if (do_rd) rptr <= rptr + (AW+1)'(1);
         overflow  <= wr_en && full;
         underflow <= rd_en && empty;
      end
   end

   generate
      if (RDATA_MODE == 0) begin : g_rd_comb
         assign rd_data = mem[rptr[AW-1:0]];
      end else begin : g_rd_reg
         logic [DATA_WIDTH-1:0] rd_q;
         always_ff @(posedge clk) begin
            if (rst)        rd_q <= '0;
            else if (do_rd) rd_q <= mem[rptr[AW-1:0]];
         end
         assign rd_data = rd_q;
      end
   endgenerate

endmodule

// File: rtl/word_out_reg.sv
// word_out_reg
//   Single-entry valid/ready holding register for packed words. A new word
//   may be loaded in the same cycle the current one is accepted downstream,
//   so back-to-back words flow without a bubble. Contents are frozen while
//   m_valid && !m_ready.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load              load request (only honoured when ld_rdy)
//   ld_data/keep/last word, byte enables and last flag to load
//   ld_rdy            register is empty or being drained this cycle
//   m_valid/m_ready   downstream handshake
//   m_data/keep/last  registered word presented downstream
module word_out_reg #(
   parameter int WORD_WIDTH = 32,
   parameter int KEEP_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [WORD_WIDTH-1:0] ld_data,
   input  logic [KEEP_WIDTH-1:0] ld_keep,
   input  logic                  ld_last,
   output logic                  ld_rdy,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [WORD_WIDTH-1:0] m_data,
   output logic [KEEP_WIDTH-1:0] m_keep,
   output logic                  m_last
);

   assign ld_rdy = !m_valid || m_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_keep  <= '0;
         m_last  <= 1'b0;
      end else if (load && ld_rdy) begin
         m_valid <= 1'b1;
         m_data  <= ld_data;
         m_keep  <= ld_keep;
         m_last  <= ld_last;
      end else if (m_ready) begin
         // drained with nothing to replace it; payload is left as-is
         m_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_word_packer.sv
// fifo_word_packer
//   Drains DATA_WIDTH entries from a sync_fifo and packs them little-endian
//   into WORD_WIDTH words (first entry popped lands in bits [DATA_WIDTH-1:0]).
//   A flush pulse emits the current partial word with contiguous byte
//   enables and m_last set. WORD_WIDTH must be a multiple of DATA_WIDTH.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   fifo_rd_en               pop request, never raised while fifo_empty
//   fifo_rd_data, fifo_empty FIFO read side (data timing per RDATA_MODE)
//   flush                    single-cycle request to emit the partial word
//   m_valid, m_ready         output handshake
//   m_data, m_keep, m_last   packed word, byte enables, flush marker
module fifo_word_packer
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int WORD_WIDTH = DEF_WORD_WIDTH,
   parameter int RDATA_MODE = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   output logic                             fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]            fifo_rd_data,
   input  logic                             fifo_empty,
   input  logic                             flush,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic [WORD_WIDTH-1:0]            m_data,
   output logic [WORD_WIDTH/DATA_WIDTH-1:0] m_keep,
   output logic                             m_last
);

   localparam int N  = pack_lanes(DATA_WIDTH, WORD_WIDTH);
   localparam int CW = cnt_width(N);

   pack_state_e                  state, state_nxt;
   logic [CW-1:0]                cnt, cnt_nxt, cap_cnt;
   logic                         inflight, capture, word_done, room;
   logic                         flush_pend, flush_pend_nxt;
   logic [N-1:0][DATA_WIDTH-1:0] asm_q, asm_cur, out_data;
   logic [N-1:0]                 out_keep;
   logic                         out_load, out_last, ld_rdy;

   // ---------------------------------------------------------------- pop
   // Counting the in-flight read keeps a registered-read FIFO from being
   // popped past the end of the word.
   assign room       = (int'(cnt) + int'(inflight)) < N;
   assign fifo_rd_en = !fifo_empty && !rst && (state == FILL) && room;

   generate
      if (RDATA_MODE == 0) begin : g_cap_now
         assign capture = fifo_rd_en;
      end else begin : g_cap_late
         assign capture = inflight;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) inflight <= 1'b0;
      else     inflight <= (RDATA_MODE != 0) && fifo_rd_en;
   end

   // cap_cnt: lanes filled once this cycle's capture (if any) is included
   assign cap_cnt   = cnt + CW'(capture);
   assign word_done = capture && (cap_cnt == CW'(N));

   // ---------------------------------------------------------------- lanes
   // asm_cur already holds this cycle's captured entry, so a word can be
   // handed to the output register in the cycle its last entry arrives.
   // Lanes at or above cap_cnt may hold stale entries and are zeroed.
   for (genvar g = 0; g < N; g++) begin : g_lane
      assign asm_cur[g]  = (capture && cnt == CW'(g)) ? fifo_rd_data : asm_q[g];
      assign out_keep[g] = cap_cnt > CW'(g);
      assign out_data[g] = out_keep[g] ? asm_cur[g] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) asm_q <= '0;
      else     asm_q <= asm_cur;
   end

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cap_cnt;
      flush_pend_nxt = flush_pend;
      out_load       = 1'b0;
      out_last       = 1'b0;
      case (state)
         FILL: begin
            if (word_done) begin
               // HOLD is only entered when the output register is busy;
               // otherwise the word goes straight out to keep one word per
               // N (mode 0) / N+1 (mode 1) cycles.
               if (ld_rdy) begin
                  out_load = 1'b1;
                  out_last = flush;
                  cnt_nxt  = '0;
               end else begin
                  state_nxt      = HOLD;
                  flush_pend_nxt = flush;
               end
            end else if (flush && !(cap_cnt == '0 && !fifo_rd_en)) begin
               // nothing assembled and nothing popped means nothing to flush
               state_nxt = FLUSH_WAIT;
            end
         end
         HOLD: begin
            if (flush) flush_pend_nxt = 1'b1;
            if (ld_rdy) begin
               out_load       = 1'b1;
               out_last       = flush_pend || flush;
               cnt_nxt        = '0;
               flush_pend_nxt = 1'b0;
               state_nxt      = FILL;
            end
         end
         FLUSH_WAIT: begin
            if (!inflight) state_nxt = (cnt == '0) ? FILL : HOLD_F;
         end
         HOLD_F: begin
            if (ld_rdy) begin
               out_load  = 1'b1;
               out_last  = 1'b1;
               cnt_nxt   = '0;
               state_nxt = FILL;
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FILL;
         cnt        <= '0;
         flush_pend <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         flush_pend <= flush_pend_nxt;
      end
   end

   // ---------------------------------------------------------------- output
   word_out_reg #(
      .WORD_WIDTH (WORD_WIDTH),
      .KEEP_WIDTH (N)
   ) u_out (
      .clk     (clk),
      .rst     (rst),
      .load    (out_load),
      .ld_data (out_data),
      .ld_keep (out_keep),
      .ld_last (out_last),
      .ld_rdy  (ld_rdy),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_keep  (m_keep),
      .m_last  (m_last)
   );

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer
//   Two sync_fifo -> fifo_word_packer pairs, one per RDATA_MODE. Every
//   scenario is run against the mode-0 pair, then the mode-1 pair, while the
//   other pair idles. A negedge monitor logs accepted beats, pops and FIFO
//   error pulses for the pair under test.
module tb_fifo_word_packer;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
      logic [31:0] t;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [1:0]       wr_en, flush, m_ready;
   logic [1:0][7:0]  wr_data, rd_data;
   logic [1:0]       full, empty, rd_en, uf, of, m_valid, m_last;
   logic [1:0][31:0] m_data;
   logic [1:0][3:0]  m_keep;

   for (genvar g = 0; g < 2; g++) begin : g_mode
      sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .RDATA_MODE(g)) u_fifo (
         .clk(clk), .rst(rst),
         .wr_en(wr_en[g]), .wr_data(wr_data[g]), .full(full[g]),
         .rd_en(rd_en[g]), .rd_data(rd_data[g]), .empty(empty[g]),
         .overflow(of[g]), .underflow(uf[g])
      );
      fifo_word_packer #(.DATA_WIDTH(8), .WORD_WIDTH(32), .RDATA_MODE(g)) u_dut (
         .clk(clk), .rst(rst),
         .fifo_rd_en(rd_en[g]), .fifo_rd_data(rd_data[g]), .fifo_empty(empty[g]),
         .flush(flush[g]),
         .m_valid(m_valid[g]), .m_ready(m_ready[g]),
         .m_data(m_data[g]), .m_keep(m_keep[g]), .m_last(m_last[g])
      );
   end

   int    md = 0;
   int    vectors = 0;
   int    miscompares = 0;
   beat_t bq[$];
   int    pops = 0, uf_cnt = 0, of_cnt = 0;
   logic [31:0] cyc = '0;

   always @(negedge clk) begin
      cyc <= cyc + 32'd1;
      if (m_valid[md] && m_ready[md])
         bq.push_back('{d: m_data[md], k: m_keep[md], l: m_last[md], t: cyc});
      if (rd_en[md]) pops   <= pops + 1;
      if (uf[md])    uf_cnt <= uf_cnt + 1;
      if (of[md])    of_cnt <= of_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      wr_en[md]   = 1'b1;
      wr_data[md] = b;
      tick();
      wr_en[md]   = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      vectors++; if (m_valid[md] !== 1'b0) begin miscompares++; $display("FAIL %s_m_valid mode=%0d got=%0b exp=0", tag, md, m_valid[md]); end
      vectors++; if (m_data[md] !== 32'h0) begin miscompares++; $display("FAIL %s_m_data mode=%0d got=%h exp=0", tag, md, m_data[md]); end
      vectors++; if (m_keep[md] !== 4'h0) begin miscompares++; $display("FAIL %s_m_keep mode=%0d got=%h exp=0", tag, md, m_keep[md]); end
      vectors++; if (m_last[md] !== 1'b0) begin miscompares++; $display("FAIL %s_m_last mode=%0d got=%0b exp=0", tag, md, m_last[md]); end
      vectors++; if (rd_en[md] !== 1'b0) begin miscompares++; $display("FAIL %s_rd_en mode=%0d got=%0b exp=0", tag, md, rd_en[md]); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      check_idle_outputs("reset");
      rst = 1'b0;
      tick();
   endtask

   task automatic test_full_word();
      int s, p0, u0;
      beat_t b;
      s = bq.size(); p0 = pops; u0 = uf_cnt;
      for (int i = 0; i < 4; i++) push_byte(8'(8'ha5 + i));
      repeat (10) tick();
      b = (bq.size() > s) ? bq[s] : '0;
      vectors++; if (bq.size() - s !== 1) begin miscompares++; $display("FAIL full_beats mode=%0d got=%0d exp=1", md, bq.size() - s); end
      vectors++; if (b.d !== 32'ha8a7a6a5) begin miscompares++; $display("FAIL full_data mode=%0d got=%h exp=a8a7a6a5", md, b.d); end
      vectors++; if (b.k !== 4'hf) begin miscompares++; $display("FAIL full_keep mode=%0d got=%h exp=f", md, b.k); end
      vectors++; if (b.l !== 1'b0) begin miscompares++; $display("FAIL full_last mode=%0d got=%0b exp=0", md, b.l); end
      vectors++; if (pops - p0 !== 4) begin miscompares++; $display("FAIL full_pops mode=%0d got=%0d exp=4", md, pops - p0); end
      vectors++; if (uf_cnt !== u0) begin miscompares++; $display("FAIL full_underflow mode=%0d got=%0d exp=%0d", md, uf_cnt, u0); end
   endtask

   task automatic test_partial_flush();
      int s, u0;
      beat_t b;
      s = bq.size(); u0 = uf_cnt;
      push_byte(8'ha5);
      push_byte(8'ha6);
      repeat (6) tick();
      flush[md] = 1'b1;
      tick();
      flush[md] = 1'b0;
      repeat (8) tick();
      b = (bq.size() > s) ? bq[s] : '0;
      vectors++; if (bq.size() - s !== 1) begin miscompares++; $display("FAIL part_beats mode=%0d got=%0d exp=1", md, bq.size() - s); end
      vectors++; if (b.d !== 32'h0000a6a5) begin miscompares++; $display("FAIL part_data mode=%0d got=%h exp=0000a6a5", md, b.d); end
      vectors++; if (b.k !== 4'h3) begin miscompares++; $display("FAIL part_keep mode=%0d got=%h exp=3", md, b.k); end
      vectors++; if (b.l !== 1'b1) begin miscompares++; $display("FAIL part_last mode=%0d got=%0b exp=1", md, b.l); end
      vectors++; if (uf_cnt !== u0) begin miscompares++; $display("FAIL part_underflow mode=%0d got=%0d exp=%0d", md, uf_cnt, u0); end
   endtask

   task automatic test_stall();
      int s, p0, u0, bad;
      logic seen;
      beat_t b0, b1;
      s = bq.size(); p0 = pops; u0 = uf_cnt; bad = 0; seen = 1'b0;
      m_ready[md] = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (c < 8) begin
            wr_en[md]   = 1'b1;
            wr_data[md] = 8'(c + 1);
         end else begin
            wr_en[md] = 1'b0;
         end
         tick();
         if (m_valid[md]) begin
            seen = 1'b1;
            if (m_data[md] !== 32'h04030201 || m_keep[md] !== 4'hf || m_last[md] !== 1'b0) bad++;
         end else if (seen) begin
            bad++;
         end
      end
      vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL stall_valid mode=%0d got=%0b exp=1", md, seen); end
      vectors++; if (bad !== 0) begin miscompares++; $display("FAIL stall_stable mode=%0d bad_cycles=%0d exp=0", md, bad); end
      vectors++; if (pops - p0 !== 8) begin miscompares++; $display("FAIL stall_pops mode=%0d got=%0d exp=8", md, pops - p0); end
      m_ready[md] = 1'b1;
      repeat (4) tick();
      b0 = (bq.size() > s)     ? bq[s]     : '0;
      b1 = (bq.size() > s + 1) ? bq[s + 1] : '0;
      vectors++; if (bq.size() - s !== 2) begin miscompares++; $display("FAIL stall_beats mode=%0d got=%0d exp=2", md, bq.size() - s); end
      vectors++; if (b0.d !== 32'h04030201) begin miscompares++; $display("FAIL stall_data0 mode=%0d got=%h exp=04030201", md, b0.d); end
      vectors++; if (b1.d !== 32'h08070605) begin miscompares++; $display("FAIL stall_data1 mode=%0d got=%h exp=08070605", md, b1.d); end
      vectors++; if (b1.t - b0.t !== 32'd1) begin miscompares++; $display("FAIL stall_gap mode=%0d got=%0d exp=1", md, b1.t - b0.t); end
      vectors++; if (empty[md] !== 1'b1) begin miscompares++; $display("FAIL stall_empty mode=%0d got=%0b exp=1", md, empty[md]); end
      vectors++; if (uf_cnt !== u0) begin miscompares++; $display("FAIL stall_underflow mode=%0d got=%0d exp=%0d", md, uf_cnt, u0); end
   endtask

   task automatic test_empty_flush();
      int s, p0, vc;
      s = bq.size(); p0 = pops; vc = 0;
      flush[md] = 1'b1;
      tick();
      flush[md] = 1'b0;
      if (m_valid[md]) vc++;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (m_valid[md]) vc++;
      end
      vectors++; if (vc !== 0) begin miscompares++; $display("FAIL eflush_valid mode=%0d got=%0d exp=0", md, vc); end
      vectors++; if (bq.size() - s !== 0) begin miscompares++; $display("FAIL eflush_beats mode=%0d got=%0d exp=0", md, bq.size() - s); end
      vectors++; if (pops - p0 !== 0) begin miscompares++; $display("FAIL eflush_pops mode=%0d got=%0d exp=0", md, pops - p0); end
   endtask

   task automatic test_flush_4th();
      int s, p0;
      logic fl_done;
      beat_t b;
      s = bq.size(); p0 = pops; fl_done = 1'b0;
      for (int c = 0; c < 16; c++) begin
         if (c < 4) begin
            wr_en[md]   = 1'b1;
            wr_data[md] = 8'(8'h11 * (c + 1));
         end else begin
            wr_en[md] = 1'b0;
         end
         // raise flush exactly in the cycle the 4th entry is popped
         flush[md] = !fl_done && rd_en[md] && (pops - p0 == 3);
         if (flush[md]) fl_done = 1'b1;
         tick();
      end
      flush[md] = 1'b0;
      b = (bq.size() > s) ? bq[s] : '0;
      vectors++; if (fl_done !== 1'b1) begin miscompares++; $display("FLUSH4 FAIL f4_issued mode=%0d got=%0b exp=1", md, fl_done); end
      vectors++; if (bq.size() - s !== 1) begin miscompares++; $display("FAIL f4_beats mode=%0d got=%0d exp=1", md, bq.size() - s); end
      vectors++; if (b.d !== 32'h44332211) begin miscompares++; $display("FAIL f4_data mode=%0d got=%h exp=44332211", md, b.d); end
      vectors++; if (b.k !== 4'hf) begin miscompares++; $display("FAIL f4_keep mode=%0d got=%h exp=f", md, b.k); end
      vectors++; if (b.l !== 1'b1) begin miscompares++; $display("FAIL f4_last mode=%0d got=%0b exp=1", md, b.l); end
      vectors++; if (pops - p0 !== 4) begin miscompares++; $display("FAIL f4_pops mode=%0d got=%0d exp=4", md, pops - p0); end
   endtask

   task automatic test_reset_mid();
      int s;
      beat_t b;
      s = bq.size();
      push_byte(8'hc1);
      push_byte(8'hc2);
      push_byte(8'hc3);
      repeat (6) tick();
      rst = 1'b1;
      tick();
      check_idle_outputs("rstmid");
      rst = 1'b0;
      for (int i = 0; i < 4; i++) push_byte(8'(8'hb0 + i));
      repeat (10) tick();
      b = (bq.size() > s) ? bq[s] : '0;
      vectors++; if (bq.size() - s !== 1) begin miscompares++; $display("FAIL rstmid_beats mode=%0d got=%0d exp=1", md, bq.size() - s); end
      vectors++; if (b.d !== 32'hb3b2b1b0) begin miscompares++; $display("FAIL rstmid_data mode=%0d got=%h exp=b3b2b1b0", md, b.d); end
      vectors++; if (b.k !== 4'hf) begin miscompares++; $display("FAIL rstmid_keep mode=%0d got=%h exp=f", md, b.k); end
      vectors++; if (b.l !== 1'b0) begin miscompares++; $display("FAIL rstmid_last mode=%0d got=%0b exp=0", md, b.l); end
   endtask

   initial begin
      rst     = 1'b1;
      wr_en   = '0;
      wr_data = '0;
      flush   = '0;
      m_ready = '1;
      for (int m = 0; m < 2; m++) begin
         md = m;
         test_reset();
         test_full_word();
         test_partial_flush();
         test_stall();
         test_empty_flush();
         test_flush_4th();
         test_reset_mid();
         vectors++; if (of_cnt !== 0) begin miscompares++; $display("FAIL overflow mode=%0d got=%0d exp=0", md, of_cnt); end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
